// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit carry-lookahead slice per clock, LSB nibble first,
// with a registered carry between slices and valid/ready on both sides.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [IW-1:0]    idx;
    logic             carry_reg;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic [IW+1:0]    base;
    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [3:0]       p;
    logic [3:0]       g;
    logic [4:0]       c;
    logic [3:0]       s_nib;
    logic             accept;

    // Accepting in DONE on the same edge the result is taken keeps the
    // issue rate at one operation per NIBBLES+1 cycles.
    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    assign base  = {idx, 2'b00};
    assign a_nib = op_a[base +: 4];
    assign b_nib = op_b[base +: 4];

    always_comb begin
        p     = a_nib ^ b_nib;
        g     = a_nib & b_nib;
        c     = '0;
        c[0]  = carry_reg;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        s_nib = p ^ c[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    sum[base +: 4] <= s_nib;
                    carry_reg      <= c[4];
                    idx            <= idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        cout  <= c[4];
                        ovf   <= c[3] ^ c[4];
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (accept) begin
                op_a      <= a;
                op_b      <= b;
                carry_reg <= cin;
                idx       <= '0;
                sum       <= '0;
                cout      <= 1'b0;
                ovf       <= 1'b0;
                state     <= S_RUN;
            end
        end
    end

endmodule
